ks_add_arbiter: RTL

Shares one Kogge-Stone prefix adder between NREQ requesters using round-robin arbitration. Each requester issues {a, b, cin} on a valid/ready handshake. The granted operation is added combinationally and captured in a one-entry output register, which returns {sum, id} on a valid/ready handshake. The block sits between client engines and the shared adder datapath, and is the only path into that adder.

---
 rtl/ks_pkg.sv | 22 ++
 rtl/ks_prefix_add.sv | 44 ++++
 rtl/ks_add_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared Kogge-Stone adder definitions.
// Width helper, default stage count and operand bundle.
package ks_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int KS_N  = 16;
  localparam int LOG2N = clog2(KS_N);

  typedef struct packed {
    logic [KS_N-1:0] a;
    logic [KS_N-1:0] b;
    logic            cin;
  } ks_op_t;

endpackage

// File: rtl/ks_prefix_add.sv
// Combinational Kogge-Stone prefix adder.
// Returns {carry_out, sum} of a + b + cin.
module ks_prefix_add
  import ks_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N:0]   sum
);

  localparam int L = clog2(N);

  // Stage s combines each bit with the one 2^(s-1) below it.
  for (genvar s = 0; s <= L; s++) begin : stg
    logic [N-1:0] gv;
    logic [N-1:0] pv;
    if (s == 0) begin : init
      assign gv = a & b;
      assign pv = a ^ b;
    end else begin : comb
      localparam int D = 1 << (s - 1);
      for (genvar i = 0; i < N; i++) begin : bitc
        if (i >= D) begin : op
          assign gv[i] = stg[s-1].gv[i]
                       | (stg[s-1].pv[i] & stg[s-1].gv[i-D]);
          assign pv[i] = stg[s-1].pv[i] & stg[s-1].pv[i-D];
        end else begin : pass
          assign gv[i] = stg[s-1].gv[i];
          assign pv[i] = stg[s-1].pv[i];
        end
      end
    end
  end

  logic [N:0] carry;

  assign carry[0]   = cin;
  assign carry[N:1] = stg[L].gv | (stg[L].pv & {N{cin}});
  assign sum        = {carry[N], stg[0].pv ^ carry[N-1:0]};

endmodule

// File: rtl/ks_add_arbiter.sv
// Round-robin arbiter sharing one prefix adder between requesters.
// Result is held in a one-entry valid/ready output register.
module ks_add_arbiter
  import ks_pkg::*;
#(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id
);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
  } op_t;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gidx;
  logic            found;
  logic [NREQ-1:0] grant;
  logic            can_accept;
  logic            fire;
  op_t             op_g;
  logic [N:0]      add_sum;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = IDW'(idx);
      end
    end
  end

  assign grant      = found ? (NREQ'(1) << gidx) : '0;
  assign can_accept = !rsp_valid || rsp_ready;
  assign req_ready  = grant & {NREQ{can_accept && !rst}};
  assign fire       = |(req_valid & req_ready);

  always_comb begin
    op_g.a   = req_a[gidx*N +: N];
    op_g.b   = req_b[gidx*N +: N];
    op_g.cin = req_cin[gidx];
  end

  ks_prefix_add #(.N(N)) u_add (
    .a   (op_g.a),
    .b   (op_g.b),
    .cin (op_g.cin),
    .sum (add_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (fire) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= add_sum;
      rsp_id    <= gidx;
      rr_ptr    <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
